// File: rtl/fb_frame_sequencer.sv
// fb_frame_sequencer: captures one raster frame into the frame buffer, then streams it out over valid/ready.
// Optional FB_SOF_RESYNC_EN: an in_sof during CAPTURE restarts the frame at address 0.
module fb_frame_sequencer #(
  parameter int DATA_WIDTH   = 24,
  parameter int IMG_WIDTH    = 176,
  parameter int IMG_HEIGHT   = 240,
  parameter int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
  parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic [DATA_WIDTH-1:0] fb_wdata,
  output logic                  fb_oe,
  output logic [ADDR_WIDTH-1:0] fb_raddr,
  input  logic [DATA_WIDTH-1:0] fb_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, READOUT} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TOTAL_PIXELS - 1);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] wcnt, rcnt;
  logic rd_all, pend, pend_last, wp, rp;
  logic [1:0] cnt, used;
  logic [DATA_WIDTH:0] mem [2];
  logic resync, last_wr, pop, fin;
`ifdef FB_SOF_RESYNC_EN
  assign resync = in_valid && in_sof && state == CAPTURE;
`else
  assign resync = 1'b0;
`endif
  always_comb begin
    in_ready = state == WAIT_SOF || state == CAPTURE;
    fb_we = !abort && in_valid && (state == CAPTURE || (state == WAIT_SOF && in_sof));
    fb_waddr = (fb_we && state == CAPTURE && !resync) ? wcnt : '0;
    fb_wdata = fb_we ? in_data : '0;
    last_wr = fb_we && state == CAPTURE && !resync && wcnt == LAST;
    out_valid = cnt != 2'd0;
    out_data = out_valid ? mem[rp][DATA_WIDTH-1:0] : '0;
    out_last = out_valid && mem[rp][DATA_WIDTH];
    pop = out_valid && out_ready;
    fin = pop && out_last;
    // an entry popped this cycle frees its slot in time for a read issued now
    used = cnt + 2'(pend) - 2'(pop);
    fb_oe = !abort && state == READOUT && !rd_all && used < 2'd2;
    fb_raddr = fb_oe ? rcnt : '0;
    busy = state != IDLE;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? WAIT_SOF : IDLE;
      WAIT_SOF: state_nx = fb_we ? CAPTURE : WAIT_SOF;
      CAPTURE:  state_nx = last_wr ? READOUT : CAPTURE;
      READOUT:  state_nx = fin ? IDLE : READOUT;
      default:  state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      wcnt <= '0;
      rcnt <= '0;
      rd_all <= 1'b0;
      pend <= 1'b0;
      pend_last <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      mem <= '{default: '0};
    end else begin
      state <= state_nx;
      done <= fin && !abort;
      if (abort) begin
        wcnt <= '0;
        rcnt <= '0;
        rd_all <= 1'b0;
        pend <= 1'b0;
        wp <= 1'b0;
        rp <= 1'b0;
        cnt <= 2'd0;
      end else begin
        if (fb_we) wcnt <= (state == WAIT_SOF || resync) ? ADDR_WIDTH'(1) : last_wr ? '0 : wcnt + ADDR_WIDTH'(1);
        // rcnt parks on the last address; rd_all marks the frame fully issued
        if (fb_oe) begin
          rd_all <= rcnt == LAST;
          rcnt <= rcnt == LAST ? rcnt : rcnt + ADDR_WIDTH'(1);
          pend_last <= rcnt == LAST;
        end
        if (fin) begin
          rcnt <= '0;
          rd_all <= 1'b0;
        end
        pend <= fb_oe;
        if (pend) begin
          mem[wp] <= {pend_last, fb_rdata};
          wp <= ~wp;
        end
        if (pop) rp <= ~rp;
        cnt <= cnt + 2'(pend) - 2'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fb_frame_sequencer.sv
// tb_fb_frame_sequencer: directed checks of capture, readout, abort and reset on a reduced 44x24 frame.
module tb_fb_frame_sequencer;
  localparam int DW = 24;
  localparam int TOT = 44 * 24;
  localparam int AW = $clog2(TOT);
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, fb_we, fb_oe, out_valid, out_last, busy, done;
  logic [AW-1:0] fb_waddr, fb_raddr;
  logic [DW-1:0] fb_wdata, fb_rdata, out_data;
  logic [DW-1:0] bmem [TOT];
  logic [DW-1:0] exp_mem [TOT];
  int vectors = 0, miscompares = 0;

  fb_frame_sequencer #(.DATA_WIDTH(DW), .IMG_WIDTH(44), .IMG_HEIGHT(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data), .in_ready(in_ready),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
    .fb_oe(fb_oe), .fb_raddr(fb_raddr), .fb_rdata(fb_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  // behavioural frame buffer: registered read, one cycle after fb_oe
  always_ff @(posedge clk) begin
    if (fb_we) bmem[fb_waddr] <= fb_wdata;
    if (fb_oe) fb_rdata <= bmem[fb_raddr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic capture(input int n_drop, input int sof_at, input int stop_at, input logic [DW-1:0] first_d);
    int ea, k;
    logic [DW-1:0] d;
    for (int i = 0; i < n_drop; i++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_data = DW'(24'h0F0F00 + i);
      #1;
      chk("drop_we", fb_we, 0);
      chk("wait_ready", in_ready, 1);
      tick;
    end
    ea = 0; k = 0;
    while (1) begin
      in_valid = 1'b1;
      in_sof = (k == 0) || (k == sof_at);
      d = (k == 0) ? first_d : (k == sof_at) ? 24'h123456 : DW'(ea);
`ifdef FB_SOF_RESYNC_EN
      if (k == sof_at) ea = 0;
`endif
      in_data = d;
      #1;
      if (k == stop_at) return;
      chk("wr_we", fb_we, 1);
      chk("wr_addr", fb_waddr, ea);
      chk("wr_data", fb_wdata, d);
      exp_mem[ea] = d;
      tick;
      k++;
      if (ea == TOT - 1) break;
      ea++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    #1;
    chk("rd_busy", busy, 1);
    chk("rd_in_ready", in_ready, 0);
    chk("rd_first_oe", fb_oe, 1);
  endtask

  task automatic readout(input bit rnd, input int stop_at);
    int exp_idx = 0, issued = 0, accepted = 0, cyc = 0, first_acc = -1, last_acc = 0;
    logic stalled = 1'b0, acc, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;
    while (cyc < 8 * TOT) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      acc = out_valid && out_ready;
      if (fb_oe) begin
        chk("credit_ok", 32'((issued - accepted - int'(acc)) <= 1), 1);
        chk("rd_addr", fb_raddr, issued);
      end
      if (acc) begin
        chk("out_data", out_data, exp_mem[exp_idx]);
        chk("out_last", out_last, exp_idx == TOT - 1);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      chk("done_low", done, 0);
      stalled = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      issued += int'(fb_oe);
      accepted += int'(acc);
      if (acc) exp_idx++;
      tick;
      cyc++;
      if (exp_idx == TOT || exp_idx == stop_at) break;
    end
    if (stop_at >= 0) begin
      chk("reached_stop", exp_idx, stop_at);
      return;
    end
    chk("all_accepted", exp_idx, TOT);
    if (!rnd) chk("throughput", last_acc - first_acc, TOT - 1);
    #1;
    chk("done_pulse", done, 1);
    chk("done_idle", busy, 0);
    chk("done_empty", out_valid, 0);
    tick;
    #1;
    chk("done_once", done, 0);
  endtask

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", fb_we, 0);
    chk("rst_oe", fb_oe, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    tick;
    rst_n = 1'b1;
    tick;
    in_valid = 1'b1; in_sof = 1'b1; in_data = 24'h555555;
    #1;
    chk("idle_we", fb_we, 0);
    chk("idle_ready", in_ready, 0);
    in_valid = 1'b0; in_sof = 1'b0;
    do_start;
    #1;
    chk("armed_busy", busy, 1);
    chk("armed_ready", in_ready, 1);
    capture(0, -1, -1, 24'h000000);
    readout(1'b0, -1);
    // drop pixels before SOF, then an in_sof mid-capture with stalled readout
    do_start;
    capture(5, 100, -1, 24'hABCDEF);
    chk("sof_word0", exp_mem[0], 24'hABCDEF);
    readout(1'b1, -1);
    // abort while stalled, with a simultaneous start that must lose
    do_start;
    capture(0, -1, -1, 24'h000000);
    readout(1'b0, 500);
    out_ready = 1'b0;
    #1;
    chk("abort_stalled", out_valid, 1);
    abort = 1'b1; start = 1'b1;
    #1;
    chk("abort_no_oe", fb_oe, 0);
    tick;
    abort = 1'b0; start = 1'b0;
    #1;
    chk("abort_idle", busy, 0);
    chk("abort_empty", out_valid, 0);
    chk("abort_no_done", done, 0);
    tick;
    #1;
    chk("abort_still_idle", busy, 0);
    chk("abort_done_low", done, 0);
    do_start;
    capture(0, -1, -1, 24'h000000);
    readout(1'b0, -1);
    // async reset mid-capture
    do_start;
    capture(0, -1, 1000, 24'h000000);
    rst_n = 1'b0;
    #1;
    chk("arst_we", fb_we, 0);
    chk("arst_waddr", fb_waddr, 0);
    chk("arst_wdata", fb_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_valid", out_valid, 0);
    in_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    do_start;
    in_valid = 1'b1; in_sof = 1'b0; in_data = 24'h000777;
    #1;
    chk("post_rst_drop", fb_we, 0);
    chk("post_rst_ready", in_ready, 1);
    in_sof = 1'b1;
    #1;
    chk("post_rst_sof_we", fb_we, 1);
    chk("post_rst_sof_addr", fb_waddr, 0);
    tick;
    in_valid = 1'b0; in_sof = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fb_frame_sequencer.md
Name: fb_frame_sequencer

Overview:
- Single-clock controller that sequences one frame through the team's dual-read-port frame buffer.
- Capture phase: writes a raster pixel stream (camera / UART loader) into sequential buffer addresses.
- Readout phase: drives read port A to stream the stored frame to the downstream processing pipeline over valid/ready.
- Sits between the pixel source, the frame buffer and the edge/plot pipeline; owns the buffer's write port and read port A.

Parameters:
- DATA_WIDTH, 24, pixel width in bits
- IMG_WIDTH, 176, pixels per line
- IMG_HEIGHT, 240, lines per frame
- TOTAL_PIXELS, IMG_WIDTH*IMG_HEIGHT, pixels per frame
- ADDR_WIDTH, $clog2(TOTAL_PIXELS), buffer address width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: arm capture of next frame (honoured only in IDLE)
- abort  in  1  synchronous abort, returns to IDLE
- in_valid  in  1  input pixel valid
- in_sof  in  1  input start-of-frame, qualified by in_valid
- in_data  in  DATA_WIDTH  input pixel
- in_ready  out  1  high in WAIT_SOF and CAPTURE only
- fb_we  out  1  buffer write enable
- fb_waddr  out  ADDR_WIDTH  buffer write address
- fb_wdata  out  DATA_WIDTH  buffer write data
- fb_oe  out  1  buffer read-port-A enable
- fb_raddr  out  ADDR_WIDTH  buffer read-port-A address
- fb_rdata  in  DATA_WIDTH  buffer read data, valid 1 cycle after fb_oe
- out_valid  out  1  output pixel valid
- out_data  out  DATA_WIDTH  output pixel
- out_last  out  1  marks pixel TOTAL_PIXELS-1
- out_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when last pixel accepted

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; output buffer empty.
- States: IDLE, WAIT_SOF, CAPTURE, READOUT.
- IDLE: start -> WAIT_SOF. in_valid ignored (in_ready=0).
- WAIT_SOF: in_valid & !in_sof -> pixel dropped. in_valid & in_sof -> combinational fb_we=1, fb_waddr=0, fb_wdata=in_data; wcnt<=1; -> CAPTURE.
- CAPTURE: each in_valid -> fb_we=1, fb_waddr=wcnt, wcnt++. The write at wcnt==TOTAL_PIXELS-1 -> READOUT; wcnt<=0. in_sof in CAPTURE handled per Optional Feature.
- Write path is combinational from inputs (zero latency); the source never stalls.
- READOUT: read issue fb_oe=1, fb_raddr=rcnt when rcnt<TOTAL_PIXELS and credits available. credits = 2 - (entries held + reads in flight). Read data lands in a 2-entry output FIFO one cycle after issue. Throughput is 1 pixel/clk under continuous out_ready.
- out_valid = FIFO non-empty. Transfer on out_valid & out_ready. out_data/out_last must hold stable while out_valid & !out_ready.
- out_last=1 only for the entry read from address TOTAL_PIXELS-1.
- Acceptance of the last pixel: done=1 for one cycle, -> IDLE, rcnt<=0.
- start outside IDLE: ignored. start & abort in the same cycle: abort wins.
- abort (any state): next cycle IDLE, counters cleared, FIFO flushed, in-flight read discarded, done not pulsed. Buffer contents are untouched.
- Async reset mid-frame: immediate return to reset values; no partial done.
- Counters are ADDR_WIDTH wide; compare against TOTAL_PIXELS-1 and never wrap past it.

Optional Feature:
- Macro: FB_SOF_RESYNC_EN.
- Defined: in CAPTURE, in_valid & in_sof restarts the frame. That pixel is written at address 0, wcnt<=1, and the state stays CAPTURE.
- Undefined: in_sof in CAPTURE is ignored. The pixel is written at the current wcnt like any other.

Test Plan:
- Reset then start, then a TOTAL_PIXELS stream with in_sof on the first pixel and data=address -> fb_waddr 0..42239 in order, READOUT entered. With out_ready=1: out_data 0..42239 at 1/clk, out_last on 42239, done pulse one cycle after that acceptance, busy low.
- Random out_ready (50%) during READOUT -> no pixel lost or duplicated; out_data stable while stalled; fb_oe never issued with 2 credits used.
- In WAIT_SOF, send 5 pixels without in_sof, then one with in_sof and data=0xABCDEF -> first 5 dropped (fb_we=0); 0xABCDEF written at address 0.
- in_sof at pixel 100 of CAPTURE, data=0x123456 -> with FB_SOF_RESYNC_EN: written at address 0, wcnt=1. Without it: written at address 100.
- abort at readout pixel 500 while stalled -> IDLE next cycle, out_valid=0, no done. A new start plus frame then completes normally.
- Assert rst_n low mid-CAPTURE at pixel 1000 -> all outputs 0 immediately; start afterwards waits for in_sof.
